// File: rtl/blink_pkg.sv
// Shared mode encodings, config field widths and restart helper for the lamp flasher.
package blink_pkg;

    localparam int unsigned CFG_CH_W = 4;
    localparam int unsigned MODE_W   = 2;

    localparam logic [MODE_W-1:0] MODE_OFF    = 2'd0;
    localparam logic [MODE_W-1:0] MODE_ON     = 2'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK  = 2'd2;
    localparam logic [MODE_W-1:0] MODE_STROBE = 2'd3;

    // Lamp level a channel takes when its phase restarts: every lit mode begins lit.
    function automatic logic restart_lit(input logic [MODE_W-1:0] mode);
        return mode != MODE_OFF;
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Shared prescaler: one registered tick pulse every TICK_DIV clocks, re-phased by sync.
module blink_tick_gen #(
    parameter int unsigned TICK_DIV = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic tick
);

    localparam int unsigned   PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          tick_q, tick_d;

    // A sync swallows any tick due this cycle so the next one lands TICK_DIV clocks later.
    always_comb begin
        pcnt_d = pcnt_q + PW'(1);
        tick_d = 1'b0;
        if (sync) begin
            pcnt_d = '0;
        end else if (pcnt_q == PCNT_MAX) begin
            pcnt_d = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_blinker.sv
// N-channel programmable lamp flasher: shared timebase, per-channel mode and half-period,
// global sync to keep all lamps flashing in phase.
module multi_blinker
    import blink_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = 500,
    parameter int unsigned HW           = 8,
    parameter int unsigned DEFAULT_HALF = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sync,
    input  logic                cfg_wr,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [MODE_W-1:0]   cfg_mode,
    input  logic [HW-1:0]       cfg_half,
    output logic                cfg_err,
    output logic                tick,
    output logic [N_CH-1:0]     blink
);

    // One extra bit so the strobe wrap point 2h-1 always fits.
    localparam int unsigned CW = HW + 1;

    logic cfg_err_q, cfg_err_d;

    blink_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .sync  (sync),
        .tick  (tick)
    );

    always_comb begin
        cfg_err_d = cfg_wr && (32'(cfg_ch) >= N_CH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [MODE_W-1:0] mode_q, mode_d;
        logic [HW-1:0]     half_q, half_d;
        logic [CW-1:0]     cnt_q, cnt_d;
        logic              blink_q, blink_d;
        logic              wr_hit;
        logic [CW-1:0]     h_ext;
        logic [CW-1:0]     cnt_inc;
        logic [CW-1:0]     strobe_nxt;

        assign wr_hit = cfg_wr && (cfg_ch == CFG_CH_W'(i));

        // Priority: addressed write, then global sync, then timebase tick.
        always_comb begin
            mode_d     = mode_q;
            half_d     = half_q;
            cnt_d      = cnt_q;
            blink_d    = blink_q;
            h_ext      = (half_q == '0) ? CW'(1) : CW'(half_q);
            cnt_inc    = cnt_q + CW'(1);
            strobe_nxt = (cnt_q >= ((h_ext << 1) - CW'(1))) ? '0 : cnt_inc;

            if (wr_hit) begin
                mode_d  = cfg_mode;
                half_d  = cfg_half;
                cnt_d   = '0;
                blink_d = restart_lit(cfg_mode);
            end else if (sync) begin
                cnt_d   = '0;
                blink_d = restart_lit(mode_q);
            end else if (tick) begin
                case (mode_q)
                    MODE_OFF: begin
                        cnt_d   = '0;
                        blink_d = 1'b0;
                    end
                    MODE_ON: begin
                        cnt_d   = '0;
                        blink_d = 1'b1;
                    end
                    MODE_BLINK: begin
                        if (cnt_q >= (h_ext - CW'(1))) begin
                            cnt_d   = '0;
                            blink_d = ~blink_q;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                    default: begin
                        cnt_d   = strobe_nxt;
                        blink_d = (strobe_nxt == '0);
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                mode_q  <= MODE_OFF;
                half_q  <= HW'(DEFAULT_HALF);
                cnt_q   <= '0;
                blink_q <= 1'b0;
            end else begin
                mode_q  <= mode_d;
                half_q  <= half_d;
                cnt_q   <= cnt_d;
                blink_q <= blink_d;
            end
        end

        assign blink[i] = blink_q;
    end

endmodule
